// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and decode helpers for the load/store unit.
package lsu_pkg;

    // RV32I funct3 width/sign codes used by loads and stores.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Two-state access sequencer: accept in IDLE, complete in RESP.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } lsu_state_e;

    // True when funct3 names a width this unit supports for the given op kind.
    function automatic logic code_legal(input logic load, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (load) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        end else begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return ok;
    endfunction

    // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never fault.
    // funct3[1:0] carries the width for both signed and unsigned variants.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        if (f3[1:0] == 2'b01) bad = lo[0];
        else if (f3[1:0] == 2'b10) bad = (lo != 2'b00);
        return bad;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/halfword of a memory word and extends it to 32 bits.
module load_extract
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection from the low address bits.
    always_comb begin
        byte_sel = 8'h00;
        case (addr)
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    // Sign/zero extension by width code; unknown codes yield zero.
    always_comb begin
        load_data = 32'h0;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_data = mem_rdata;
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Turns one core load/store micro-op into a single data-memory request and
// returns the aligned, extended load result one cycle later.
//
// Handshake: the core raises ls_valid with the op fields and holds them stable
// while stall=1. The op is accepted in the first IDLE cycle it is seen, memory
// outputs are driven combinationally in that cycle only, and done pulses for
// exactly one cycle in the following (RESP) cycle, at which point stall drops.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ls_valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        done,
    output logic        stall,
    output logic        misaligned,
    output logic        mem_request,
    output logic        mem_we_re,
    output logic [3:0]  mem_mask,
    output logic [11:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output lsu_state_e  fsm_state
);

    lsu_state_e  state;
    lsu_state_e  state_next;
    logic        accept;
    logic        err_now;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic        load_q;
    logic        err_q;
    logic [31:0] ext_data;

    // Upper address bits select nothing in a 4096-word memory.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:14];

    assign fsm_state = state;

    // State register and captured op attributes for the response cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            f3_q   <= 3'b000;
            lo_q   <= 2'b00;
            load_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                f3_q   <= funct3;
                lo_q   <= addr[1:0];
                load_q <= is_load;
                err_q  <= err_now;
            end
        end
    end

    // Next state, error decode and memory request drive for the accept cycle.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        err_now     = 1'b0;
        mem_request = 1'b0;
        mem_we_re   = 1'b0;
        mem_mask    = 4'b0000;
        mem_address = 12'h000;
        mem_wdata   = 32'h0;
        case (state)
            ST_IDLE: begin
                if (ls_valid) begin
                    accept     = 1'b1;
                    state_next = ST_RESP;
                    // Ambiguous op flags, unsupported width or bad alignment
                    // all reject the op without touching memory.
                    err_now = ~(is_load ^ is_store) ||
                              !code_legal(is_load, funct3) ||
                              is_misaligned(funct3, addr[1:0]);
                    if (!err_now) begin
                        mem_request = 1'b1;
                        mem_we_re   = is_store;
                        mem_address = addr[13:2];
                        if (is_store) begin
                            case (funct3)
                                F3_B: begin
                                    mem_mask  = 4'b0001 << addr[1:0];
                                    mem_wdata = {4{store_data[7:0]}};
                                end
                                F3_H: begin
                                    mem_mask  = 4'b0011 << {addr[1], 1'b0};
                                    mem_wdata = {2{store_data[15:0]}};
                                end
                                default: begin
                                    mem_mask  = 4'b1111;
                                    mem_wdata = store_data;
                                end
                            endcase
                        end
                    end
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    load_extract u_load_extract (
        .funct3    (f3_q),
        .addr      (lo_q),
        .mem_rdata (mem_rdata),
        .load_data (ext_data)
    );

    // Completion outputs; reset during RESP swallows the done pulse.
    always_comb begin
        done       = (state == ST_RESP) && !rst;
        misaligned = done && err_q;
        load_data  = (done && load_q && !err_q) ? ext_data : 32'h0;
        stall      = ls_valid && !done;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-masked, registered-read memory.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic        ls_valid;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        done;
    logic        stall;
    logic        misaligned;
    logic        mem_request;
    logic        mem_we_re;
    logic [3:0]  mem_mask;
    logic [11:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    lsu_state_e  fsm_state;

    int checks;
    int errors;

    logic [31:0] mem [0:4095];

    load_store_unit dut (
        .clk         (clk),
        .rst         (rst),
        .ls_valid    (ls_valid),
        .is_load     (is_load),
        .is_store    (is_store),
        .funct3      (funct3),
        .addr        (addr),
        .store_data  (store_data),
        .load_data   (load_data),
        .done        (done),
        .stall       (stall),
        .misaligned  (misaligned),
        .mem_request (mem_request),
        .mem_we_re   (mem_we_re),
        .mem_mask    (mem_mask),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .fsm_state   (fsm_state)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory model: byte-lane writes, one-cycle registered reads.
    always @(posedge clk) begin
        if (mem_request) begin
            if (mem_we_re) begin
                for (int l = 0; l < 4; l++) begin
                    if (mem_mask[l]) mem[mem_address][l*8 +: 8] <= mem_wdata[l*8 +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_address];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        ls_valid = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
    endtask

    // Presents one op at a negedge, checks the accept cycle, then the RESP cycle.
    // ls_valid is left asserted so back-to-back ops can follow directly.
    task automatic op(input string tag, input logic ld, input logic st,
                      input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                      input logic exp_req, input logic [3:0] exp_mask,
                      input logic [31:0] exp_wdata, input logic exp_mis,
                      input logic [31:0] exp_ldata);
        @(negedge clk);
        ls_valid   = 1'b1;
        is_load    = ld;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = d;
        #1;
        chk({tag, ".req"}, {31'h0, mem_request}, {31'h0, exp_req});
        chk({tag, ".stall_acc"}, {31'h0, stall}, 32'h1);
        if (exp_req) begin
            chk({tag, ".we"}, {31'h0, mem_we_re}, {31'h0, st});
            chk({tag, ".mask"}, {28'h0, mem_mask}, {28'h0, exp_mask});
            if (st) chk({tag, ".wdata"}, mem_wdata, exp_wdata);
        end
        @(negedge clk);
        #1;
        chk({tag, ".done"}, {31'h0, done}, 32'h1);
        chk({tag, ".mis"}, {31'h0, misaligned}, {31'h0, exp_mis});
        chk({tag, ".ldata"}, load_data, exp_ldata);
        chk({tag, ".req_resp"}, {31'h0, mem_request}, 32'h0);
        chk({tag, ".stall_resp"}, {31'h0, stall}, 32'h0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        ls_valid   = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        store_data = 32'h0;
        mem_rdata  = 32'h0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[8] = 32'h8001F07F;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("rst.done", {31'h0, done}, 32'h0);
        chk("rst.mis", {31'h0, misaligned}, 32'h0);
        chk("rst.ldata", load_data, 32'h0);
        chk("rst.req", {31'h0, mem_request}, 32'h0);
        chk("rst.state", {31'h0, fsm_state}, {31'h0, ST_IDLE});
        @(negedge clk);
        rst = 1'b0;

        // SW 0x10 with explicit word address check in the accept cycle.
        @(negedge clk);
        ls_valid = 1'b1; is_load = 1'b0; is_store = 1'b1;
        funct3 = F3_W; addr = 32'h10; store_data = 32'hDEADBEEF;
        #1;
        chk("sw.addr", {20'h0, mem_address}, 32'h4);
        chk("sw.mask", {28'h0, mem_mask}, 32'hF);
        chk("sw.req", {31'h0, mem_request}, 32'h1);
        chk("sw.we", {31'h0, mem_we_re}, 32'h1);
        @(negedge clk);
        #1;
        chk("sw.done", {31'h0, done}, 32'h1);
        chk("sw.ldata", load_data, 32'h0);
        idle();
        chk("sw.mem", mem[4], 32'hDEADBEEF);

        // SB 0x13, then LW 0x10 sees the merged byte.
        op("sb", 1'b0, 1'b1, F3_B, 32'h13, 32'h000000A5, 1'b1, 4'b1000, 32'hA5A5A5A5, 1'b0, 32'h0);
        idle();
        op("lw10", 1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b0, 32'hA5ADBEEF);
        idle();

        // Extraction from 0x8001F07F at 0x20; upper address bits ignored on one.
        op("lb20", 1'b1, 1'b0, F3_B, 32'h20, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b0, 32'h0000007F);
        idle();
        op("lb21", 1'b1, 1'b0, F3_B, 32'hFFFF_C021, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b0, 32'hFFFFFFF0);
        idle();
        op("lhu22", 1'b1, 1'b0, F3_HU, 32'h22, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b0, 32'h00008001);
        idle();
        op("lh22", 1'b1, 1'b0, F3_H, 32'h22, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b0, 32'hFFFF8001);
        idle();
        op("lbu21", 1'b1, 1'b0, F3_BU, 32'h21, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b0, 32'h000000F0);
        idle();

        // Misaligned and illegal ops: no request, done+misaligned, memory untouched.
        op("lw22", 1'b1, 1'b0, F3_W, 32'h22, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0);
        idle();
        op("sh21", 1'b0, 1'b1, F3_H, 32'h21, 32'h0000FFFF, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0);
        idle();
        chk("sh21.mem", mem[8], 32'h8001F07F);
        op("ld_f3_3", 1'b1, 1'b0, 3'b011, 32'h20, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0);
        idle();
        op("both", 1'b1, 1'b1, F3_W, 32'h20, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0);
        idle();
        op("neither", 1'b0, 1'b0, F3_W, 32'h20, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0);
        idle();

        // SH 0x22 writes the upper halfword lanes.
        op("sh22", 1'b0, 1'b1, F3_H, 32'h22, 32'h00001234, 1'b1, 4'b1100, 32'h12341234, 1'b0, 32'h0);
        idle();
        chk("sh22.mem", mem[8], 32'h1234F07F);

        // Reset in the RESP cycle of an LW.
        @(negedge clk);
        ls_valid = 1'b1; is_load = 1'b1; is_store = 1'b0;
        funct3 = F3_W; addr = 32'h10;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstresp.done", {31'h0, done}, 32'h0);
        chk("rstresp.ldata", load_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ls_valid = 1'b0; is_load = 1'b0;
        #1;
        chk("rstresp.state", {31'h0, fsm_state}, {31'h0, ST_IDLE});
        chk("rstresp.done2", {31'h0, done}, 32'h0);
        op("lw_after_rst", 1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b0, 32'hA5ADBEEF);
        idle();

        // Back-to-back SW then LW with ls_valid held: stall 1,0,1,0 (checked in op).
        op("b2b_sw", 1'b0, 1'b1, F3_W, 32'h40, 32'hCAFEF00D, 1'b1, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0);
        op("b2b_lw", 1'b1, 1'b0, F3_W, 32'h40, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b0, 32'hCAFEF00D);
        idle();
        #1;
        chk("end.stall", {31'h0, stall}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
